// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush control with memory-wait FSM and performance counters.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   rs1_id_i, rs2_id_i              source registers of the instruction in ID
//   rs1_used_id_i, rs2_used_id_i    ID instruction actually reads rs1 / rs2
//   rd_ex_i, mem_read_ex_i          destination register / load flag of the instruction in EX
//   branch_taken_ex_i               branch or jump in EX redirects the PC
//   mem_req_mem_i, mem_ready_i      data-memory access in MEM / access completes this cycle
//   cnt_clr_i                       synchronous clear of the performance counters
//   *_write_o, *_flush_o            pipeline register enables and bubble inserts
//   mem_error_o                     sticky memory-timeout indication
//   stall_cnt_o, flush_cnt_o        saturating stall-cycle and flush-event counts
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rs1_id_i,
    input  logic [4:0]       rs2_id_i,
    input  logic             rs1_used_id_i,
    input  logic             rs2_used_id_i,
    input  logic [4:0]       rd_ex_i,
    input  logic             mem_read_ex_i,
    input  logic             branch_taken_ex_i,
    input  logic             mem_req_mem_i,
    input  logic             mem_ready_i,
    input  logic             cnt_clr_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             mem_wb_flush_o,
    output logic             mem_error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

    state_e             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic               mem_error_q, mem_error_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic               mem_stall, branch_flush, load_use;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The RUN cycle that first sees the miss is not-ready cycle 1, so the
    // first MEM_WAIT cycle (wait_q = 0) is cycle 2 and timeout fires at MEM_TIMEOUT-2.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: if (mem_req_mem_i && !mem_ready_i) begin
                state_d = MEM_WAIT;
                wait_d  = '0;
            end
            MEM_WAIT: if (mem_ready_i) state_d = RUN;
                else if (wait_q == 8'(MEM_TIMEOUT - 2)) state_d = ERROR;
                else wait_d = wait_q + 8'd1;
            default: state_d = ERROR;
        endcase
        mem_error_d = mem_error_q || state_d == ERROR;
        stall_cnt_d = cnt_clr_i ? '0
                    : (!pc_write_o && state_q != ERROR && stall_cnt_q != '1) ? stall_cnt_q + 1'b1
                    : stall_cnt_q;
        flush_cnt_d = cnt_clr_i ? '0
                    : (branch_flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1
                    : flush_cnt_q;
    end

    always_comb begin
        mem_stall      = state_q == ERROR || !mem_ready_i && (state_q == MEM_WAIT || mem_req_mem_i);
        branch_flush   = !mem_stall && branch_taken_ex_i;
        load_use       = !mem_stall && !branch_taken_ex_i && mem_read_ex_i && rd_ex_i != 5'd0 &&
                         ((rs1_used_id_i && rs1_id_i == rd_ex_i) || (rs2_used_id_i && rs2_id_i == rd_ex_i));
        pc_write_o     = rst_ni && !mem_stall && !load_use;
        if_id_write_o  = rst_ni && !mem_stall && !load_use;
        id_ex_write_o  = rst_ni && !mem_stall;
        ex_mem_write_o = rst_ni && !mem_stall;
        if_id_flush_o  = !rst_ni || branch_flush;
        id_ex_flush_o  = !rst_ni || branch_flush || load_use;
        mem_wb_flush_o = !rst_ni || mem_stall;
        mem_error_o    = mem_error_q;
        stall_cnt_o    = stall_cnt_q;
        flush_cnt_o    = flush_cnt_q;
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and randomized checks of hazard_control_unit against a behavioural model.
module tb_hazard_control_unit;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, br, mq, rdy, clr;
    logic pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int ntests = 0, nfail = 0;
    int m_stall = 0, m_flush = 0, m_nr = 0;
    bit m_err = 0, m_acc = 0;

    hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rs1_id_i(rs1), .rs2_id_i(rs2),
        .rs1_used_id_i(u1), .rs2_used_id_i(u2), .rd_ex_i(rd), .mem_read_ex_i(mr),
        .branch_taken_ex_i(br), .mem_req_mem_i(mq), .mem_ready_i(rdy), .cnt_clr_i(clr),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .id_ex_write_o(idex_w), .ex_mem_write_o(exmem_w),
        .if_id_flush_o(ifid_f), .id_ex_flush_o(idex_f), .mem_wb_flush_o(memwb_f),
        .mem_error_o(mem_err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        ntests++;
        if (obs != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ctl();
        return {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f};
    endfunction

    task automatic idle();
        {rs1, rs2, rd, u1, u2, mr, br, mq, rdy, clr} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        check("rst_ctl", ctl(), 7'b0000111);
        check("rst_stall", int'(stall_cnt), 0);
        check("rst_flush", int'(flush_cnt), 0);
        check("rst_err", int'(mem_err), 0);
        {m_stall, m_flush, m_nr, m_err, m_acc} = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle, check the combinational response and the registered
    // state against the model, then advance the model across the coming edge.
    task automatic step(input logic [4:0] a, b, d, input logic s1, s2, ld, bt, rq, ok, cl);
        bit stall, lu, bf;
        @(negedge clk);
        {rs1, rs2, rd, u1, u2, mr, br, mq, rdy, clr} = {a, b, d, s1, s2, ld, bt, rq, ok, cl};
        #1;
        stall = m_err || (!ok && (m_acc || rq));
        lu = !stall && !bt && ld && d != 0 && ((s1 && a == d) || (s2 && b == d));
        bf = !stall && bt;
        check("ctl", ctl(), {!stall && !lu, !stall && !lu, !stall, !stall, bf, bf || lu, stall});
        check("stall_cnt", int'(stall_cnt), m_stall);
        check("flush_cnt", int'(flush_cnt), m_flush);
        check("mem_err", int'(mem_err), int'(m_err));
        if (cl) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if ((stall || lu) && !m_err && m_stall < MAXC) m_stall++;
            if (bf && m_flush < MAXC) m_flush++;
        end
        if (!m_err) begin
            if (stall) begin
                m_nr = m_acc ? m_nr + 1 : 1;
                m_acc = 1;
                if (m_nr >= TO) m_err = 1;
            end else begin
                m_acc = 0;
                m_nr = 0;
            end
        end
    endtask

    task automatic after_edge(input string tag, input int obs_sel, input int exp);
        @(posedge clk);
        #1;
        check(tag, obs_sel == 0 ? int'(stall_cnt) : obs_sel == 1 ? int'(flush_cnt) : int'(mem_err), exp);
    endtask

    initial begin
        idle();
        #2;
        check("por_ctl", ctl(), 7'b0000111);
        do_reset();
        step(5, 0, 5, 1, 0, 1, 0, 0, 1, 0);
        after_edge("lu_stall_cnt", 0, 1);
        step(5, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        step(5, 0, 5, 0, 0, 1, 0, 0, 1, 0);
        after_edge("nolu_stall_cnt", 0, 1);
        step(5, 0, 5, 1, 0, 1, 1, 0, 1, 0);
        after_edge("br_flush_cnt", 1, 1);
        check("br_stall_cnt", int'(stall_cnt), 1);
        do_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        after_edge("memwait_stall_cnt", 0, 3);
        check("memwait_flush_cnt", int'(flush_cnt), 1);
        do_reset();
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        after_edge("timeout_err", 2, 1);
        check("timeout_stall_cnt", int'(stall_cnt), TO);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (MAXC + 4) step(3, 0, 3, 1, 0, 1, 0, 0, 1, 0);
        after_edge("sat_stall_cnt", 0, MAXC);
        step(3, 0, 3, 1, 0, 1, 0, 0, 1, 1);
        after_edge("clr_stall_cnt", 0, 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(59) == 0) do_reset();
            step(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3) == 0,
                 $urandom_range(2) == 0, $urandom_range(2) != 0, $urandom_range(29) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 16: max consecutive wait cycles on a data-memory access before an error is raised (range 2..255).
REQ-002 SHALL provide parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  pipeline clock; all state updates on the rising edge.
REQ-005 RST_n  in  1  asynchronous active-low reset.
REQ-006 Rs1_ID, Rs2_ID  in  5 each  source registers of the instruction in ID.
REQ-007 Rs1_used_ID, Rs2_used_ID  in  1 each  the instruction in ID actually reads Rs1 / Rs2.
REQ-008 Rd_EX  in  5  destination register of the instruction in EX.
REQ-009 MemRead_EX  in  1  the instruction in EX is a load.
REQ-010 Branch_taken_EX  in  1  a branch or jump in EX redirects the PC.
REQ-011 Mem_req_MEM  in  1  the instruction in MEM is a load or store.
REQ-012 Mem_ready  in  1  data memory completes the access this cycle.
REQ-013 Cnt_clr  in  1  synchronous clear of the performance counters.
REQ-014 PCWrite, IF_ID_Write  out  1 each  PC / IF-ID register update enable.
REQ-015 ID_EX_Write, EX_MEM_Write  out  1 each  ID-EX / EX-MEM register update enable.
REQ-016 IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load a bubble into that register.
REQ-017 Mem_error  out  1  sticky memory-timeout indication.
REQ-018 Stall_cnt, Flush_cnt  out  CNT_W each  saturating counts of stall cycles and flush events.

Function
REQ-019 SHALL implement FSM states RUN, MEM_WAIT, ERROR.
REQ-020 Default (RUN, no hazard): all Write outputs = 1, all Flush outputs = 0.
REQ-021 Memory stall: when (RUN and Mem_req_MEM and !Mem_ready) or state = MEM_WAIT with !Mem_ready, SHALL set PCWrite = IF_ID_Write = ID_EX_Write = EX_MEM_Write = 0, MEM_WB_Flush = 1, other flushes = 0, in the same cycle.
REQ-022 RUN -> MEM_WAIT on Mem_req_MEM and !Mem_ready; MEM_WAIT -> RUN on Mem_ready, and that cycle SHALL produce the default outputs.
REQ-023 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; a MEM_TIMEOUT-th consecutive not-ready cycle (counting the RUN cycle) SHALL move the FSM to ERROR.
REQ-024 ERROR SHALL hold the memory-stall outputs of REQ-021 and Mem_error = 1 until reset; Mem_ready is ignored.
REQ-025 Control hazard (no memory stall active): Branch_taken_EX SHALL set IF_ID_Flush = ID_EX_Flush = 1 with all Write outputs = 1.
REQ-026 Load-use hazard (no memory stall, no Branch_taken_EX): MemRead_EX and Rd_EX != 0 and ((Rs1_used_ID and Rs1_ID == Rd_EX) or (Rs2_used_ID and Rs2_ID == Rd_EX)) SHALL set PCWrite = IF_ID_Write = 0 and ID_EX_Flush = 1, with other outputs at default.
REQ-027 Priority SHALL be memory stall > branch flush > load-use stall. A branch held in EX during a memory stall is flushed on the first non-stalled cycle.
REQ-028 Stall_cnt SHALL increment by 1 on every cycle with PCWrite = 0 outside ERROR.
REQ-029 Flush_cnt SHALL increment by 1 on every cycle applying REQ-025.
REQ-030 Both counters SHALL saturate at 2^CNT_W-1.
REQ-031 Cnt_clr SHALL zero both counters next edge, overriding any increment in the same cycle.
REQ-032 Hazard decisions SHALL be combinational from the current state and inputs, with zero-cycle latency; only state, the wait counter, Mem_error and the performance counters are registered.

Reset
REQ-033 RST_n low SHALL immediately force state RUN, wait counter 0, Mem_error 0, Stall_cnt 0, Flush_cnt 0.
REQ-034 While RST_n is low, SHALL drive all Write outputs 0 and all Flush outputs 1.
REQ-035 Reset asserted during MEM_WAIT or ERROR SHALL abandon the access; after release, outputs follow REQ-020..027 from the first edge.

Verification
REQ-036 Load-use: MemRead_EX=1, Rd_EX=5, Rs1_ID=5, Rs1_used_ID=1 for one cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle; Stall_cnt 0->1.
REQ-037 Same as REQ-036 with Rd_EX=0, or with Rs1_used_ID=0 -> default outputs; Stall_cnt unchanged.
REQ-038 Branch_taken_EX=1 together with the load-use condition -> IF_ID_Flush=ID_EX_Flush=1, PCWrite=1; Flush_cnt +1, Stall_cnt +0.
REQ-039 Mem_req_MEM=1, Mem_ready low 3 cycles then high -> 3 full-freeze cycles with MEM_WB_Flush=1, then RUN; Stall_cnt=3.
REQ-040 MEM_TIMEOUT=4, Mem_ready held low -> ERROR after 4 stalled cycles, Mem_error=1 and sticky; RST_n pulse returns to RUN with Mem_error=0.
REQ-041 Preload Stall_cnt to 2^CNT_W-1 and stall -> value holds; Cnt_clr asserted with a stall -> 0 next edge.
